// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin packet arbiter: state encoding
// and requester-count constants.
package mux4_rr_arbiter_pkg;

    localparam int NUM_REQ   = 4;
    localparam int SEL_WIDTH = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/mux4_rr_arbiter_mux_4.sv
// Plain 4:1 data multiplexer used to steer the granted requester's data word
// onto the shared downstream channel.
module mux_4
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int data_length = 27
) (
    input  logic [data_length-1:0] in_0,
    input  logic [data_length-1:0] in_1,
    input  logic [data_length-1:0] in_2,
    input  logic [data_length-1:0] in_3,
    input  logic [SEL_WIDTH-1:0]   sel,
    output logic [data_length-1:0] out
);

    // Select one of the four data words.
    always_comb begin
        case (sel)
            2'd0:    out = in_0;
            2'd1:    out = in_1;
            2'd2:    out = in_2;
            2'd3:    out = in_3;
            default: out = in_0;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready data channel among 4 requesters;
// a grant is held from the first beat of a packet through its last beat.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int data_length    = 27,
    parameter int beat_cnt_width = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [data_length-1:0]    req_data_0,
    input  logic [data_length-1:0]    req_data_1,
    input  logic [data_length-1:0]    req_data_2,
    input  logic [data_length-1:0]    req_data_3,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [data_length-1:0]    out_data,
    input  logic                      out_ready,
    output logic [SEL_WIDTH-1:0]      grant_id,
    output logic                      busy,
    output logic [beat_cnt_width-1:0] beat_cnt
);

    localparam logic [beat_cnt_width-1:0] BEAT_MAX = {beat_cnt_width{1'b1}};

    state_t                    state_r;
    logic [SEL_WIDTH-1:0]      grant_id_r;
    logic [SEL_WIDTH-1:0]      rr_ptr_r;
    logic [beat_cnt_width-1:0] beat_cnt_r;

    logic [SEL_WIDTH-1:0]      winner_s;
    logic [SEL_WIDTH-1:0]      idx_s;
    logic                      found_s;
    logic                      xfer_s;

    // Next winner: first valid requester scanning upward from rr_ptr+1 with wrap.
    always_comb begin
        winner_s = 2'd0;
        found_s  = 1'b0;
        idx_s    = 2'd0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx_s = rr_ptr_r + 2'(i);
            if (!found_s && req_valid[idx_s]) begin
                winner_s = idx_s;
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Handshake pass-through for the held grant; everything is quiet in IDLE.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        req_ready = 4'b0000;
        if (state_r == GRANT) begin
            out_valid             = req_valid[grant_id_r];
            out_last              = req_last[grant_id_r];
            req_ready[grant_id_r] = out_ready;
        end else begin
            out_valid = 1'b0;
            out_last  = 1'b0;
            req_ready = 4'b0000;
        end
    end

    assign xfer_s = out_valid & out_ready;

    // Arbitration state, held grant, round-robin pointer and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            grant_id_r <= 2'd0;
            rr_ptr_r   <= 2'd3;
            beat_cnt_r <= {beat_cnt_width{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (|req_valid) begin
                        grant_id_r <= winner_s;
                        state_r    <= GRANT;
                        beat_cnt_r <= {beat_cnt_width{1'b0}};
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                GRANT: begin
                    if (xfer_s) begin
                        if (beat_cnt_r != BEAT_MAX) begin
                            beat_cnt_r <= beat_cnt_r + 1'b1;
                        end else begin
                            beat_cnt_r <= beat_cnt_r;
                        end
                        if (out_last) begin
                            state_r  <= IDLE;
                            rr_ptr_r <= grant_id_r;
                        end else begin
                            state_r  <= GRANT;
                        end
                    end else begin
                        state_r <= GRANT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign grant_id = grant_id_r;
    assign busy     = (state_r == GRANT);
    assign beat_cnt = beat_cnt_r;

    // Data steering follows the held grant, also while idle.
    mux_4 #(
        .data_length (data_length)
    ) u_mux (
        .in_0 (req_data_0),
        .in_1 (req_data_1),
        .in_2 (req_data_2),
        .in_3 (req_data_3),
        .sel  (grant_id_r),
        .out  (out_data)
    );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: per-requester packet sources, an
// expected-beat scoreboard in grant order, and a narrow-counter second instance.
module tb_mux4_rr_arbiter;

    localparam int DL = 27;

    typedef struct packed {
        logic [1:0]    id;
        logic [DL-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req_valid;
    logic [3:0]    req_last;
    logic [DL-1:0] req_data [4];
    logic [3:0]    req_ready;
    logic          out_valid;
    logic          out_last;
    logic [DL-1:0] out_data;
    logic          out_ready;
    logic [1:0]    grant_id;
    logic          busy;
    logic [7:0]    beat_cnt;

    logic [3:0]    s_req_valid;
    logic [3:0]    s_req_last;
    logic [DL-1:0] s_req_data_0;
    logic [3:0]    s_req_ready;
    logic          s_out_valid;
    logic          s_out_last;
    logic [DL-1:0] s_out_data;
    logic          s_out_ready;
    logic [1:0]    s_grant_id;
    logic          s_busy;
    logic [1:0]    s_beat_cnt;

    int            n_checks;
    int            n_pass;
    int            cyc;
    exp_t          exp_q [$];
    int            xfer_cyc [$];
    int            cnt_log [$];
    logic          last_prev;
    logic [3:0]    en;
    logic [DL:0]   src_mem [4][64];
    int            src_head [4];
    int            src_tail [4];
    logic [3:0]    smp_req_ready;
    logic          smp_busy;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.data_length(DL), .beat_cnt_width(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
        .req_data_0(req_data[0]), .req_data_1(req_data[1]),
        .req_data_2(req_data[2]), .req_data_3(req_data[3]),
        .req_ready(req_ready), .out_valid(out_valid), .out_last(out_last),
        .out_data(out_data), .out_ready(out_ready), .grant_id(grant_id),
        .busy(busy), .beat_cnt(beat_cnt)
    );

    mux4_rr_arbiter #(.data_length(DL), .beat_cnt_width(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(s_req_valid), .req_last(s_req_last),
        .req_data_0(s_req_data_0), .req_data_1({DL{1'b0}}),
        .req_data_2({DL{1'b0}}), .req_data_3({DL{1'b0}}),
        .req_ready(s_req_ready), .out_valid(s_out_valid), .out_last(s_out_last),
        .out_data(s_out_data), .out_ready(s_out_ready), .grant_id(s_grant_id),
        .busy(s_busy), .beat_cnt(s_beat_cnt)
    );

    task automatic clear_tb();
        for (int i = 0; i < 4; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
        exp_q.delete();
        xfer_cyc.delete();
        cnt_log.delete();
        last_prev = 1'b0;
    endtask

    task automatic add_packet(input int id, input int base, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            src_mem[id][src_tail[id]] = {(k == n - 1), DL'(base + k)};
            src_tail[id]++;
            e.id   = 2'(id);
            e.data = DL'(base + k);
            e.last = (k == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            if (src_head[i] < src_tail[i] && en[i]) begin
                req_valid[i] = 1'b1;
                {req_last[i], req_data[i]} = src_mem[i][src_head[i]];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    // One clock: drive sources, sample and score at negedge, advance after posedge.
    task automatic cycle();
        logic [3:0] hs;
        exp_t       e;
        drive_inputs();
        @(negedge clk);
        cyc++;
        smp_req_ready = req_ready;
        smp_busy      = busy;
        if (last_prev) cnt_log.push_back(int'(beat_cnt));
        last_prev = out_valid && out_ready && out_last;
        if (out_valid && out_ready) begin
            xfer_cyc.push_back(cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got id=%0d data=%0h, expected no transfer", grant_id, out_data);
            end else begin
                e = exp_q.pop_front();
                if (grant_id !== e.id || out_data !== e.data || out_last !== e.last)
                    $display("FAIL sb_beat: got id=%0d data=%0h last=%0b, expected id=%0d data=%0h last=%0b",
                             grant_id, out_data, out_last, e.id, e.data, e.last);
                else
                    n_pass++;
            end
        end
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (hs[i]) src_head[i]++;
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL sb_timeout: %0d beats still pending, expected 0", exp_q.size());
        else
            n_pass++;
        cycle();
        cycle();
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({out_valid, out_last, busy, req_ready, grant_id, beat_cnt} !== 16'h0000)
            $display("FAIL reset_state: got v=%0b l=%0b busy=%0b rdy=%0h gid=%0d cnt=%0d, expected all 0",
                     out_valid, out_last, busy, req_ready, grant_id, beat_cnt);
        else
            n_pass++;
        n_checks++;
        if (s_busy !== 1'b0 || s_beat_cnt !== 2'd0 || s_out_valid !== 1'b0)
            $display("FAIL reset_sat: got busy=%0b cnt=%0d v=%0b, expected 0 0 0", s_busy, s_beat_cnt, s_out_valid);
        else
            n_pass++;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        int c0;
        clear_tb();
        for (int i = 0; i < 4; i++) add_packet(i, 16 + i, 1);
        add_packet(0, 32, 1);
        c0 = cyc;
        run_until_done(40);
        n_checks++;
        if (xfer_cyc.size() != 5) begin
            $display("FAIL rr_count: got %0d transfers, expected 5", xfer_cyc.size());
        end else begin
            n_pass++;
            n_checks++;
            if (xfer_cyc[0] - c0 !== 2) $display("FAIL rr_latency: got %0d, expected 2", xfer_cyc[0] - c0);
            else n_pass++;
            for (int i = 1; i < 5; i++) begin
                n_checks++;
                if (xfer_cyc[i] - xfer_cyc[i-1] !== 2)
                    $display("FAIL rr_gap%0d: got %0d cycles, expected 2", i, xfer_cyc[i] - xfer_cyc[i-1]);
                else
                    n_pass++;
            end
        end
    endtask

    task automatic test_hold_grant();
        clear_tb();
        en = 4'b1101;
        add_packet(2, 5, 3);
        add_packet(1, 9, 1);
        cycle();
        cycle();
        en = 4'b1111;
        run_until_done(40);
        n_checks++;
        if (xfer_cyc.size() < 3 || xfer_cyc[1] - xfer_cyc[0] !== 1 || xfer_cyc[2] - xfer_cyc[1] !== 1)
            $display("FAIL hold_contiguous: got %0d transfers not back-to-back, expected 3 contiguous", xfer_cyc.size());
        else
            n_pass++;
        n_checks++;
        if (cnt_log.size() == 0 || cnt_log[0] !== 3)
            $display("FAIL hold_beat_cnt: got %0d, expected 3", (cnt_log.size() == 0) ? -1 : cnt_log[0]);
        else
            n_pass++;
    endtask

    task automatic test_stall();
        bit [8:0] en_pat  = 9'b111110011;
        bit [8:0] rdy_pat = 9'b111010111;
        logic [3:0] exp_rdy;
        logic       exp_busy;
        clear_tb();
        add_packet(3, 20, 4);
        for (int c = 0; c < 9; c++) begin
            en[3]     = en_pat[c];
            out_ready = rdy_pat[c];
            cycle();
            exp_busy = (c >= 1 && c <= 7);
            exp_rdy  = exp_busy ? {rdy_pat[c], 3'b000} : 4'b0000;
            n_checks++;
            if (smp_req_ready !== exp_rdy || smp_busy !== exp_busy)
                $display("FAIL stall_c%0d: got rdy=%0h busy=%0b, expected rdy=%0h busy=%0b",
                         c, smp_req_ready, smp_busy, exp_rdy, exp_busy);
            else
                n_pass++;
        end
        en = 4'b1111;
        out_ready = 1'b1;
        n_checks++;
        if (exp_q.size() != 0 || src_head[3] != src_tail[3])
            $display("FAIL stall_drain: got %0d pending beats, expected 0", exp_q.size());
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_tb();
        for (int p = 0; p < 3; p++) add_packet(0, 60 + 2 * p, 2);
        run_until_done(40);
        n_checks++;
        if (xfer_cyc.size() != 6 || xfer_cyc[2] - xfer_cyc[1] !== 2 || xfer_cyc[4] - xfer_cyc[3] !== 2)
            $display("FAIL b2b_overhead: got %0d transfers, expected 6 with 1 idle cycle between packets", xfer_cyc.size());
        else
            n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (cnt_log.size() <= i || cnt_log[i] !== 2)
                $display("FAIL b2b_cnt%0d: got %0d, expected 2", i, (cnt_log.size() <= i) ? -1 : cnt_log[i]);
            else
                n_pass++;
        end
    endtask

    task automatic test_reset_mid_packet();
        clear_tb();
        add_packet(1, 40, 4);
        cycle();
        cycle();
        drive_inputs();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_last, busy, req_ready, grant_id, beat_cnt} !== 16'h0000)
            $display("FAIL rst_mid_clear: got v=%0b l=%0b busy=%0b rdy=%0h gid=%0d cnt=%0d, expected all 0",
                     out_valid, out_last, busy, req_ready, grant_id, beat_cnt);
        else
            n_pass++;
        n_checks++;
        if (exp_q.size() != 3) $display("FAIL rst_mid_accepted: got %0d beats left, expected 3", exp_q.size());
        else n_pass++;
        clear_tb();
        drive_inputs();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        add_packet(0, 70, 1);
        add_packet(2, 80, 1);
        run_until_done(40);
    endtask

    task automatic test_saturation();
        int  b = 0;
        int  exp_cnt;
        logic xfer;
        s_out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            s_req_valid  = {3'b000, (b < 6)};
            s_req_last   = {3'b000, (b == 5)};
            s_req_data_0 = DL'(100 + b);
            @(negedge clk);
            exp_cnt = (c == 0) ? 0 : (c >= 7) ? 3 : ((c - 1 > 3) ? 3 : c - 1);
            n_checks++;
            if (c >= 1 && c <= 6) begin
                if (s_out_valid !== 1'b1 || s_out_data !== DL'(100 + c - 1) ||
                    s_beat_cnt !== 2'(exp_cnt) || s_out_last !== (c == 6))
                    $display("FAIL sat_c%0d: got v=%0b data=%0d cnt=%0d last=%0b, expected 1 %0d %0d %0b",
                             c, s_out_valid, s_out_data, s_beat_cnt, s_out_last, 100 + c - 1, exp_cnt, (c == 6));
                else
                    n_pass++;
            end else begin
                if (s_busy !== 1'b0 || s_beat_cnt !== 2'(exp_cnt))
                    $display("FAIL sat_c%0d: got busy=%0b cnt=%0d, expected 0 %0d", c, s_busy, s_beat_cnt, exp_cnt);
                else
                    n_pass++;
            end
            xfer = s_out_valid && s_out_ready;
            @(posedge clk);
            #1;
            if (xfer) b++;
        end
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        cyc          = 0;
        rst_n        = 1'b0;
        out_ready    = 1'b1;
        en           = 4'b1111;
        req_valid    = 4'b0000;
        req_last     = 4'b0000;
        for (int i = 0; i < 4; i++) req_data[i] = {DL{1'b0}};
        s_req_valid  = 4'b0000;
        s_req_last   = 4'b0000;
        s_req_data_0 = {DL{1'b0}};
        s_out_ready  = 1'b0;
        clear_tb();
        test_reset();
        test_round_robin();
        test_hold_grant();
        test_stall();
        test_back_to_back();
        test_reset_mid_packet();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream data channel among 4 upstream requesters, e.g. 4 neuron-group result streams writing into one activation buffer.
- Generates the 2-bit select for the 4:1 data mux and routes the valid/ready handshake.
- Holds a grant for a whole packet, from first beat through the beat flagged last.
- Sits between the PE output stage and the shared write port.

Parameters:
- data_length, 27, width of each requester data word and of out_data.
- beat_cnt_width, 8, width of the per-packet beat counter; the counter saturates at its maximum value.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  4  per-requester beat valid; bit i belongs to requester i.
- req_last  input  4  per-requester last-beat flag; qualified by req_valid.
- req_data_0..req_data_3  input  data_length each  per-requester data.
- req_ready  output  4  per-requester ready; at most one bit is high.
- out_valid  output  1  downstream beat valid.
- out_last  output  1  downstream last flag.
- out_data  output  data_length  selected data.
- out_ready  input  1  downstream ready.
- grant_id  output  2  current select value; drives the mux select.
- busy  output  1  high in the GRANT state.
- beat_cnt  output  beat_cnt_width  beats accepted in the current packet.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE; grant_id = 0; rr_ptr = 3, so requester 0 has first priority; beat_cnt = 0.
  - Outputs during and after reset: out_valid = 0, req_ready = 0, busy = 0, out_last = 0.
  - Reset asserted mid-packet abandons the packet immediately. No beat is accepted in the cycle rst_n is low.
- States: IDLE and GRANT.
- IDLE:
  - out_valid = 0 and req_ready = 0.
  - If any req_valid bit is high, pick the first requester with valid high, searching from rr_ptr+1 mod 4 upward with wrap-around.
  - On the clock edge: grant_id <= winner, state <= GRANT, beat_cnt <= 0.
  - Arbitration latency is 1 cycle from valid to the first possible transfer.
- GRANT, with g = grant_id:
  - Combinational pass-through: out_valid = req_valid[g], out_last = req_last[g], out_data = req_data_g, req_ready[g] = out_ready. All other req_ready bits are 0.
  - A transfer is a cycle with out_valid and out_ready both high. Each transfer increments beat_cnt, saturating.
  - A transfer with out_last high ends the packet: on the edge, state <= IDLE and rr_ptr <= g.
  - The requester dropping valid mid-packet does not release the grant; the arbiter waits indefinitely.
  - Requests from other requesters during GRANT are ignored until the packet completes.
- Single-beat packet: last is high on the first beat; GRANT lasts exactly one transfer cycle.
- Back-to-back packets: a requester that just finished has the lowest priority in the next arbitration. If it is the only requester, it wins again after 1 IDLE cycle.
- Minimum per-packet overhead: 1 IDLE cycle.
- out_data in IDLE equals req_data of the held grant_id. This value is don't-care for downstream and must not be relied upon.
- busy = (state == GRANT). grant_id is stable for the whole of GRANT.
- No combinational path exists from out_ready to req_valid. The only combinational path from out_ready is to req_ready.

Decomposition:
- Shared package holds the state encoding (IDLE = 0, GRANT = 1) and the requester count constant (4).
- One sub-module: the existing MUX_4, instantiated with data_length passed through, sel = grant_id, producing out_data.
- The next-winner rotate-and-priority-encode logic stays inline.

Test Plan:
- Reset then req_valid = 4'b1111, all packets 1 beat, out_ready = 1 → grants in order 0, 1, 2, 3, 0, with 1 IDLE cycle between each transfer.
- Requester 2 sends a 3-beat packet (data 5, 6, 7) while requester 1 asserts valid mid-packet → out_data shows 5, 6, 7 contiguously with grant_id = 2; requester 1 is granted next; beat_cnt reaches 3.
- Granted requester 3 drops valid for 2 cycles mid-packet, and out_ready toggles 1, 0, 1 → no beat is lost or duplicated; req_ready[3] mirrors out_ready; other req_ready bits stay 0.
- Only requester 0 is active with repeated packets → repeated grants to 0 with exactly 1 IDLE cycle of overhead each.
- rst_n pulsed low during beat 2 of a 4-beat packet → outputs clear asynchronously; after release the arbiter is in IDLE with rr_ptr = 3, and the next grant goes to the lowest active index.
- beat_cnt_width = 2 with a 6-beat packet → beat_cnt saturates at 3; the packet still terminates on last.
